// File: rtl/fpalu_pkg.sv
// fpalu_pkg: shared state type, chunk layout and key indices for the FP operand loader
package fpalu_pkg;

    typedef enum logic [1:0] {ENTRY, FULL, WAIT} state_t;

    localparam int NUM_KEYS   = 4;
    localparam int KEY_ENTER  = 0;
    localparam int KEY_COMMIT = 1;
    localparam int KEY_CLEAR  = 2;
    localparam int KEY_SWAP   = 3;

    localparam int CHUNK_W    = 10;
    localparam int CHUNK0_LSB = 22;
    localparam int CHUNK1_LSB = 12;
    localparam int CHUNK2_LSB = 2;
    localparam int CHUNK3_LSB = 0;
    localparam int CHUNK3_W   = 2;

    function automatic logic [31:0] put_chunk(input logic [31:0] shadow,
                                              input logic [1:0]  ptr,
                                              input logic [9:0]  sw);
        logic [31:0] r;
        r = shadow;
        case (ptr)
            2'd0:    r[CHUNK0_LSB +: CHUNK_W]  = sw;
            2'd1:    r[CHUNK1_LSB +: CHUNK_W]  = sw;
            2'd2:    r[CHUNK2_LSB +: CHUNK_W]  = sw;
            default: r[CHUNK3_LSB +: CHUNK3_W] = sw[CHUNK3_W-1:0];
        endcase
        return r;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce: 2-FF synchronizer, optional stability filter (OPLOAD_DEBOUNCE_EN) and press-edge detect
// Ports: iclock, ireset (async, active-high), ikey_n (raw active-low key), opress (one-cycle press event)
module key_debounce
    import fpalu_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic iclock,
    input  logic ireset,
    input  logic ikey_n,
    output logic opress
);

    logic s1_q, s2_q, prev_q, level;

    always_ff @(posedge iclock or posedge ireset) begin
        if (ireset) begin
            s1_q   <= 1'b1;
            s2_q   <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            s1_q   <= ikey_n;
            s2_q   <= s1_q;
            prev_q <= level;
        end
    end

`ifdef OPLOAD_DEBOUNCE_EN
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;

    // Any return to the accepted level restarts the count, so only an
    // uninterrupted run of DEBOUNCE_CYCLES differing samples is accepted.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (s2_q != level_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) level_d = s2_q;
            else cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge iclock or posedge ireset) begin
        if (ireset) begin
            cnt_q   <= '0;
            level_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level = level_q;
`else
    assign level = s2_q;
`endif

    assign opress = prev_q & ~level;

endmodule

// File: rtl/fp_operand_loader.sv
// fp_operand_loader: builds 32-bit FP operands from switch chunks and commits A/B pairs to the FPALU wrapper
// Ports: iclock, ireset (async, active-high), ikey[3:0] (active-low enter/commit/clear/swap), isw[9:0] chunk value,
//        iready downstream accept; odataa/odatab committed operands, oshadow operand under construction,
//        optr next chunk, otarget commit destination (0=A, 1=B), ostart pair-complete pulse, obusy in FULL/WAIT.
// Build option: OPLOAD_DEBOUNCE_EN enables the DEBOUNCE_CYCLES key filter.
module fp_operand_loader
    import fpalu_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic        iclock,
    input  logic        ireset,
    input  logic [3:0]  ikey,
    input  logic [9:0]  isw,
    input  logic        iready,
    output logic [31:0] odataa,
    output logic [31:0] odatab,
    output logic [31:0] oshadow,
    output logic [1:0]  optr,
    output logic        otarget,
    output logic        ostart,
    output logic        obusy
);

    logic [NUM_KEYS-1:0] press;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .iclock (iclock),
            .ireset (ireset),
            .ikey_n (ikey[k]),
            .opress (press[k])
        );
    end

    state_t      state_q, state_d;
    logic [31:0] dataa_q, dataa_d, datab_q, datab_d, shadow_q, shadow_d;
    logic [1:0]  ptr_q, ptr_d;
    logic        target_q, target_d, start_q, start_d, busy_q, busy_d;

    // Priority clear > commit > enter > swap; commit only acts in FULL and
    // swap only in ENTRY with no chunks entered, so each state sees one action.
    always_comb begin
        state_d  = state_q;
        dataa_d  = dataa_q;
        datab_d  = datab_q;
        shadow_d = shadow_q;
        ptr_d    = ptr_q;
        target_d = target_q;
        start_d  = 1'b0;
        if (press[KEY_CLEAR]) begin
            shadow_d = '0;
            ptr_d    = '0;
            state_d  = ENTRY;
        end else begin
            case (state_q)
                ENTRY: begin
                    if (press[KEY_ENTER]) begin
                        shadow_d = put_chunk(shadow_q, ptr_q, isw);
                        ptr_d    = ptr_q + 2'd1;
                        state_d  = (ptr_q == 2'd3) ? FULL : ENTRY;
                    end else if (press[KEY_SWAP] && ptr_q == 2'd0) begin
                        target_d = ~target_q;
                    end
                end
                FULL: state_d = press[KEY_COMMIT] ? WAIT : FULL;
                WAIT: begin
                    if (iready) begin
                        dataa_d  = target_q ? dataa_q : shadow_q;
                        datab_d  = target_q ? shadow_q : datab_q;
                        start_d  = target_q;
                        target_d = ~target_q;
                        shadow_d = '0;
                        state_d  = ENTRY;
                    end
                end
                default: state_d = ENTRY;
            endcase
        end
        busy_d = (state_d != ENTRY);
    end

    always_ff @(posedge iclock or posedge ireset) begin
        if (ireset) begin
            state_q  <= ENTRY;
            dataa_q  <= '0;
            datab_q  <= '0;
            shadow_q <= '0;
            ptr_q    <= '0;
            target_q <= 1'b0;
            start_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            dataa_q  <= dataa_d;
            datab_q  <= datab_d;
            shadow_q <= shadow_d;
            ptr_q    <= ptr_d;
            target_q <= target_d;
            start_q  <= start_d;
            busy_q   <= busy_d;
        end
    end

    assign odataa  = dataa_q;
    assign odatab  = datab_q;
    assign oshadow = shadow_q;
    assign optr    = ptr_q;
    assign otarget = target_q;
    assign ostart  = start_q;
    assign obusy   = busy_q;

endmodule
